// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the divide-by-zero quotient pattern.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // Step counter must hold WIDTH-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] s;
    logic [WIDTH:0] d_ext;
    // A stored partial remainder is always below the divisor, so its top bit is zero.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem[WIDTH];
    assign s              = {rem[WIDTH-1:0], q_msb};
    assign d_ext          = {1'b0, divisor};
    assign q_bit          = (s >= d_ext);
    assign rem_next       = q_bit ? (s - d_ext) : s;

endmodule

// File: rtl/seq_div_8bit.sv
// Iterative unsigned divider: one quotient bit per clock, valid/ready on both
// sides, results held in DONE until the consumer takes them.
module seq_div_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dz_reg, dz_next;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .q_msb    (q_reg[WIDTH-1]),
        .divisor  (div_reg),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            rem_reg   <= '0;
            div_reg   <= '0;
            cnt_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            rem_reg   <= rem_next;
            div_reg   <= div_next;
            cnt_reg   <= cnt_next;
            dz_reg    <= dz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rem_next   = rem_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        dz_next    = dz_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    div_next = divisor;
                    if (divisor == '0) begin
                        // Zero divisor skips iteration and loads the fixed result directly.
                        q_next     = '1;
                        rem_next   = {1'b0, dividend};
                        dz_next    = 1'b1;
                        state_next = DONE;
                    end else begin
                        q_next     = dividend;
                        rem_next   = '0;
                        dz_next    = 1'b0;
                        cnt_next   = CW'(WIDTH - 1);
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                q_next   = {q_reg[WIDTH-2:0], step_qbit};
                rem_next = step_rem;
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = q_reg;
    assign remainder   = rem_reg[WIDTH-1:0];
    assign div_by_zero = dz_reg;

endmodule
